bcd_timekeeper: RTL and testbench
=================================

// Module: bcd_timekeeper
// PURPOSE
// - Parametrised successor to the fixed 24 h hour/minute counter feeding the binary-clock display.
// - Keeps HH:MM:SS in BCD, advanced by a 1 Hz enable strobe in the main CLK domain.
// - Adds a 12/24 h display mode, a PM flag and a midnight ROLLOVER pulse.
// - Set button: debounced, with selectable hour/minute field and hold-to-auto-repeat.
// - Sits between the tick divider and the LED/WS2812 display encoders.
// PARAMETERS
// MAIN_CLK              12000000  CLK frequency in Hz (informational; derive cycle params from it)
// DEBOUNCE_CYCLES       240000    consecutive stable synchronised BTN samples to accept press/release (>=1)
// REPEAT_DELAY_CYCLES   6000000   hold time after accepted press before auto-repeat starts (>=1)
// REPEAT_CYCLES         1200000   auto-repeat step period while held (>=1)
// PORTS
// CLK         in   1  main clock
// RST         in   1  synchronous, active-high reset
// TICK        in   1  1 Hz enable strobe, one CLK cycle wide
// BTN         in   1  raw set button, active-low, asynchronous (2-flop synchronised inside)
// SET_HOURS   in   1  1: set steps hours; 0: set steps minutes
// MODE_12H    in   1  1: 12 h display; 0: 24 h display
// DH1,DH0     out  4  hour tens/units BCD (display-converted)
// DM1,DM0     out  4  minute tens/units BCD
// DS1,DS0     out  4  second tens/units BCD
// PM          out  1  internal hour >= 12 (valid in both modes)
// ROLLOVER    out  1  one-cycle pulse when a TICK wraps 23:59:59 -> 00:00:00
// SET_ACTIVE  out  1  high while a debounced press is held
// BEHAVIOUR
// - Time is held internally as a 24 h BCD counter. All outputs are registered.
// - On RST: internal time 00:00:00; every output 0, including the digit outputs, PM, ROLLOVER and
//   SET_ACTIVE; button FSM to IDLE; all counters cleared.
// - Display latency: outputs reflect internal state 1 cycle later.
//   The first cycle after RST therefore shows 00:00:00 even when MODE_12H=1.
// - 12 h conversion: hour 0 -> 12; hours 1..12 unchanged; hours 13..23 -> h-12.
// - MODE_12H may change at any time. It never alters the internal time.
// - Counting (TICK=1, SET_ACTIVE=0):
//   - seconds +1; 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours.
//   - 23:59:59 -> 00:00:00: ROLLOVER=1 in the same cycle the new digits appear.
// - Set step:
//   - SET_HOURS=0: minutes +1 mod 60, no carry into hours.
//   - SET_HOURS=1: hours +1 mod 24.
//   - Every step clears seconds to 00. A set wrap never raises ROLLOVER.
//   - SET_HOURS is sampled at each step.
// - Button FSM (on synchronised BTN, bs; "low"/"high" = bs level):
//   - IDLE: bs low -> PRESS_DB, counter = 1.
//   - PRESS_DB: bs high -> IDLE. Counter reaches DEBOUNCE_CYCLES -> HOLD_DELAY, issue one step,
//     SET_ACTIVE=1.
//   - HOLD_DELAY: bs high -> RELEASE_DB. After REPEAT_DELAY_CYCLES in state -> REPEAT, issue one step.
//   - REPEAT: one step every REPEAT_CYCLES while bs low. bs high -> RELEASE_DB.
//   - RELEASE_DB: bs low -> back to the hold state it came from, with its timer restarted.
//     High for DEBOUNCE_CYCLES -> IDLE, SET_ACTIVE=0.
//   - Any bounce restarts the debounce counter.
// - TICK while SET_ACTIVE=1 is discarded; seconds stay frozen at 00.
// - TICK and step in the same cycle: the step wins and the TICK is discarded.
// - RST mid-hold: returns to IDLE. A BTN still held through reset must be re-debounced from zero
//   before the next step.
// TESTING
// (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=8, REPEAT_CYCLES=2)
// 1 RST, then TICK every cycle for 86399 ticks -> 23:59:59, ROLLOVER=0 throughout; next TICK ->
//   00:00:00 with ROLLOVER=1 for exactly 1 cycle.
// 2 MODE_12H=1 at internal 00:00 -> DH1=1, DH0=2, PM=0; at 12:00 -> 12, PM=1; at 13:05 -> 01:05, PM=1;
//   toggle MODE_12H -> display changes, internal time unchanged.
// 3 BTN low 3 cycles / high 1 cycle, repeated 5 times -> no step, SET_ACTIVE=0; then low steady ->
//   minutes 00 -> 01 once, SET_ACTIVE=1.
// 4 SET_HOURS=1 at 22:10:37, hold BTN -> 23:10:00 on press; 8 cycles later -> 00:10:00; +2 cycles
//   -> 01:10:00; no ROLLOVER; release -> SET_ACTIVE=0 after debounce.
// 5 TICK asserted on the step cycle and during the hold -> only set steps occur, seconds remain 00;
//   after release TICKs resume 00 -> 01.
// 6 RST pulsed mid-REPEAT with BTN held -> 00:00:00 and SET_ACTIVE=0 next cycle; next step only
//   after 4 stable-low synchronised samples.

Source files
------------

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: 24 h BCD HH:MM:SS counter with 12 h display,
// midnight pulse and a debounced, auto-repeating set button.
module bcd_timekeeper #(
  parameter int MAIN_CLK            = 12000000,
  parameter int DEBOUNCE_CYCLES     = MAIN_CLK / 50,
  parameter int REPEAT_DELAY_CYCLES = MAIN_CLK / 2,
  parameter int REPEAT_CYCLES       = MAIN_CLK / 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       BTN,
  input  logic       SET_HOURS,
  input  logic       MODE_12H,
  output logic [3:0] DH1,
  output logic [3:0] DH0,
  output logic [3:0] DM1,
  output logic [3:0] DM0,
  output logic [3:0] DS1,
  output logic [3:0] DS0,
  output logic       PM,
  output logic       ROLLOVER,
  output logic       SET_ACTIVE
);

  localparam int MAX_AB =
    (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_C =
    (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST =
    CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RP_LAST =
    CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HOLD_DELAY,
    S_REPEAT,
    S_RELEASE_DB
  } state_t;

  logic          btn_m;
  logic          bs;
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] rel_cnt;
  logic          rep_q;
  logic          rep_d;
  logic          step;
  logic          rel;
  logic          held;

  logic [7:0] sec_q;
  logic [7:0] min_q;
  logic [7:0] hr_q;
  logic [7:0] sec_d;
  logic [7:0] min_d;
  logic [7:0] hr_d;
  logic       roll_q;
  logic       roll_d;
  logic [8:0] s_inc;
  logic [8:0] m_inc;
  logic [8:0] h_inc;

  logic [4:0] hr_bin;
  logic [4:0] hr12;
  logic [7:0] hr_disp;

  // Released level on reset so a held button is re-debounced.
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_m <= 1'b1;
      bs    <= 1'b1;
    end else begin
      btn_m <= BTN;
      bs    <= btn_m;
    end
  end

  assign held = (state_q == S_HOLD_DELAY) ||
                (state_q == S_REPEAT) ||
                (state_q == S_RELEASE_DB);

  assign rel_cnt =
    (state_q == S_RELEASE_DB) ? cnt_q : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  // cnt_q is always zero in S_IDLE, so IDLE shares the press path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    step    = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      S_IDLE, S_PRESS_DB: begin
        if (bs) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_HOLD_DELAY;
          cnt_d   = '0;
          step    = 1'b1;
        end else begin
          state_d = S_PRESS_DB;
          cnt_d   = cnt_q + ONE;
        end
      end
      S_HOLD_DELAY: begin
        if (bs) begin
          rep_d = 1'b0;
          rel   = 1'b1;
        end else if (cnt_q == RD_LAST) begin
          state_d = S_REPEAT;
          cnt_d   = '0;
          step    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_REPEAT: begin
        if (bs) begin
          rep_d = 1'b1;
          rel   = 1'b1;
        end else if (cnt_q == RP_LAST) begin
          cnt_d = '0;
          step  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_RELEASE_DB: begin
        if (!bs) begin
          state_d = rep_q ? S_REPEAT : S_HOLD_DELAY;
          cnt_d   = '0;
        end else begin
          rel = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (rel) begin
      if (rel_cnt == DB_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_RELEASE_DB;
        cnt_d   = rel_cnt + ONE;
      end
    end
  end

  // Returns {wrap, tens, units}; wraps to 00 after 'last'.
  function automatic logic [8:0] inc_bcd(
    input logic [7:0] v,
    input logic [7:0] last
  );
    logic [8:0] r;
    r = {1'b0, v[7:4], v[3:0] + 4'd1};
    if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'd0};
    if (v == last)
      r = 9'h100;
    return r;
  endfunction

  assign s_inc = inc_bcd(sec_q, 8'h59);
  assign m_inc = inc_bcd(min_q, 8'h59);
  assign h_inc = inc_bcd(hr_q, 8'h23);

  // A set step takes priority and swallows a coincident tick.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hr_d   = hr_q;
    roll_d = 1'b0;
    if (step) begin
      sec_d = 8'h00;
      if (SET_HOURS)
        hr_d = h_inc[7:0];
      else
        min_d = m_inc[7:0];
    end else if (TICK && !held) begin
      sec_d = s_inc[7:0];
      if (s_inc[8]) begin
        min_d = m_inc[7:0];
        if (m_inc[8]) begin
          hr_d   = h_inc[7:0];
          roll_d = h_inc[8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      hr_q   <= 8'h00;
      roll_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      roll_q <= roll_d;
    end
  end

  assign hr_bin = 5'(hr_q[7:4]) * 5'd10 +
                  5'(hr_q[3:0]);

  always_comb begin
    hr12 = hr_bin;
    if (hr_bin == 5'd0)
      hr12 = 5'd12;
    else if (hr_bin > 5'd12)
      hr12 = hr_bin - 5'd12;
    hr_disp = {4'd0, hr12[3:0]};
    if (hr12 >= 5'd10)
      hr_disp = {4'd1, 4'(hr12 - 5'd10)};
  end

  // ROLLOVER is delayed with the digits so both land together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DH1        <= 4'd0;
      DH0        <= 4'd0;
      DM1        <= 4'd0;
      DM0        <= 4'd0;
      DS1        <= 4'd0;
      DS0        <= 4'd0;
      PM         <= 1'b0;
      ROLLOVER   <= 1'b0;
      SET_ACTIVE <= 1'b0;
    end else begin
      {DH1, DH0} <= MODE_12H ? hr_disp : hr_q;
      {DM1, DM0} <= min_q;
      {DS1, DS0} <= sec_q;
      PM         <= (hr_q >= 8'h12);
      ROLLOVER   <= roll_q;
      SET_ACTIVE <= held;
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: directed vectors for bcd_timekeeper
// with short debounce/repeat timing.
module tb_bcd_timekeeper;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TICK;
  logic       BTN;
  logic       SET_HOURS;
  logic       MODE_12H;
  logic [3:0] DH1;
  logic [3:0] DH0;
  logic [3:0] DM1;
  logic [3:0] DM0;
  logic [3:0] DS1;
  logic [3:0] DS0;
  logic       PM;
  logic       ROLLOVER;
  logic       SET_ACTIVE;

  logic [23:0] disp;
  int n_chk  = 0;
  int n_fail = 0;
  logic seen;

  assign disp = {DH1, DH0, DM1, DM0, DS1, DS0};

  bcd_timekeeper #(
    .MAIN_CLK(12000000),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(8),
    .REPEAT_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .TICK(TICK),
    .BTN(BTN),
    .SET_HOURS(SET_HOURS),
    .MODE_12H(MODE_12H),
    .DH1(DH1),
    .DH0(DH0),
    .DM1(DM1),
    .DM0(DM0),
    .DS1(DS1),
    .DS0(DS0),
    .PM(PM),
    .ROLLOVER(ROLLOVER),
    .SET_ACTIVE(SET_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One clean press: step + SET_ACTIVE after 7 cycles,
  // SET_ACTIVE drops 7 cycles after release.
  task automatic press();
    int k;
    BTN = 1'b0;
    k = 0;
    while (!SET_ACTIVE && k < 20) begin
      cyc();
      k++;
    end
    check("press_lat", k, 7);
    BTN = 1'b1;
    k = 0;
    while (SET_ACTIVE && k < 20) begin
      cyc();
      k++;
    end
    check("release_lat", k, 7);
  endtask

  initial begin
    RST       = 1'b1;
    TICK      = 1'b0;
    BTN       = 1'b1;
    SET_HOURS = 1'b0;
    MODE_12H  = 1'b1;
    cyc(2);
    check("rst_digits", disp, 24'h000000);
    check("rst_flags", {PM, ROLLOVER, SET_ACTIVE}, 0);
    RST = 1'b0;
    cyc();
    check("first_12h", disp, 24'h120000);
    check("first_pm", PM, 0);
    MODE_12H = 1'b0;
    cyc();
    check("first_24h", disp, 24'h000000);

    // full day of ticks
    TICK = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 86399; k++) begin
      cyc();
      seen |= ROLLOVER;
      if (k == 3662)
        check("t_010101", disp, 24'h010101);
    end
    TICK = 1'b0;
    cyc();
    check("t_235959", disp, 24'h235959);
    check("roll_quiet", seen | ROLLOVER, 0);
    TICK = 1'b1;
    cyc();
    TICK = 1'b0;
    check("roll_early", ROLLOVER, 0);
    cyc();
    check("wrap_digits", disp, 24'h000000);
    check("roll_pulse", ROLLOVER, 1);
    cyc();
    check("roll_end", ROLLOVER, 0);

    // 12 h display
    MODE_12H = 1'b1;
    cyc();
    check("h12_0000", disp, 24'h120000);
    check("pm_0000", PM, 0);
    SET_HOURS = 1'b1;
    repeat (12) press();
    check("h12_1200", disp, 24'h120000);
    check("pm_1200", PM, 1);
    press();
    SET_HOURS = 1'b0;
    repeat (5) press();
    check("h12_1305", disp, 24'h010500);
    check("pm_1305", PM, 1);
    MODE_12H = 1'b0;
    cyc();
    check("h24_1305", disp, 24'h130500);
    check("pm_24h", PM, 1);
    MODE_12H = 1'b1;
    cyc();
    check("h12_back", disp, 24'h010500);
    MODE_12H = 1'b0;

    // bounce rejection
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      BTN = 1'b0;
      repeat (3) begin
        cyc();
        seen |= SET_ACTIVE;
      end
      BTN = 1'b1;
      cyc();
      seen |= SET_ACTIVE;
    end
    repeat (4) begin
      cyc();
      seen |= SET_ACTIVE;
    end
    check("bounce_act", seen, 0);
    check("bounce_time", disp, 24'h000000);
    press();
    check("bounce_step", disp, 24'h000100);

    // hour set with auto-repeat through midnight
    repeat (9) press();
    SET_HOURS = 1'b1;
    repeat (22) press();
    TICK = 1'b1;
    cyc(37);
    TICK = 1'b0;
    cyc();
    check("pre_hold", disp, 24'h221037);
    BTN = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      cyc();
      seen |= ROLLOVER;
      if (k == 7) begin
        check("hold_step", disp, 24'h231000);
        check("hold_act", SET_ACTIVE, 1);
      end
      if (k == 14)
        check("hold_wait", disp, 24'h231000);
      if (k == 15) begin
        check("rep_first", disp, 24'h001000);
        BTN = 1'b1;
      end
      if (k == 16)
        check("rep_gap", disp, 24'h001000);
      if (k == 17)
        check("rep_second", disp, 24'h011000);
      if (k == 21)
        check("rel_held", SET_ACTIVE, 1);
      if (k == 22) begin
        check("rel_done", SET_ACTIVE, 0);
        check("rel_time", disp, 24'h011000);
      end
    end
    check("set_no_roll", seen, 0);

    // tick suppressed while set is active
    SET_HOURS = 1'b0;
    BTN = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k == 5)
        TICK = 1'b1;
      if (k >= 7 && k <= 14)
        seen |= (disp[7:0] != 8'h00);
      if (k == 7) begin
        check("tick_step", disp, 24'h011100);
        check("tick_act", SET_ACTIVE, 1);
        BTN = 1'b1;
      end
      if (k == 14) begin
        check("tick_rel", SET_ACTIVE, 0);
        TICK = 1'b0;
      end
      if (k == 15)
        check("tick_resume", disp, 24'h011101);
      if (k == 16)
        check("tick_single", disp, 24'h011101);
    end
    check("tick_frozen", seen, 0);

    // reset mid-repeat with button held
    BTN = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (k == 15)
        check("rep_pre_rst", disp, 24'h011300);
      if (k == 16)
        RST = 1'b1;
      if (k == 17) begin
        RST = 1'b0;
        check("mid_rst", disp, 24'h000000);
        check("mid_rst_act", SET_ACTIVE, 0);
      end
      if (k >= 18 && k <= 23)
        seen |= SET_ACTIVE | (disp != 24'h0);
      if (k == 24) begin
        check("redb_step", disp, 24'h000100);
        check("redb_act", SET_ACTIVE, 1);
      end
    end
    check("redb_quiet", seen, 0);
    BTN = 1'b1;
    begin
      int k;
      k = 0;
      while (SET_ACTIVE && k < 20) begin
        cyc();
        k++;
      end
      check("final_rel", k, 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
